step_gear: RTL

STEP_GEAR -- requirements
Module: step_gear

---
 rtl/step_gear_pkg.sv | 12 +
 rtl/step_gear_if.sv | 34 +++
 rtl/btn_debounce.sv | 43 ++++
 rtl/step_gear.sv | 116 +++++++++++
 4 files changed

// File: rtl/step_gear_pkg.sv
// Shared types and constants for the step_gear clock-enable controller.
package step_gear_pkg;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StHalt = 2'd1,
        StStep = 2'd2
    } state_e;

    localparam int unsigned StepCountW = 16;

endpackage

// File: rtl/step_gear_if.sv
// Button and clock-enable bundle of step_gear; step_count exists only with STEP_COUNT_EN.
interface step_gear_if;

    logic btn_mode;
    logic btn_step;
    logic ce;
    logic running;
`ifdef STEP_COUNT_EN
    logic [step_gear_pkg::StepCountW-1:0] step_count;
`endif

    // Board / bench side: drives buttons, observes the enable.
    modport master (
        output btn_mode,
        output btn_step,
`ifdef STEP_COUNT_EN
        input  step_count,
`endif
        input  ce,
        input  running
    );

    // Controller side.
    modport slave (
        input  btn_mode,
        input  btn_step,
`ifdef STEP_COUNT_EN
        output step_count,
`endif
        output ce,
        output running
    );

endinterface

// File: rtl/btn_debounce.sv
// Raw button to single-cycle press pulse: 2-flop synchronizer, counting debouncer, rise detect.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    logic                     sync1_q;
    logic                     sync2_q;
    logic                     level_q;
    logic                     press_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (&cnt_q) begin
                // 2^DEBOUNCE_BITS consecutive differing samples: accept the new level.
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + DEBOUNCE_BITS'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/step_gear.sv
// RUN/HALT/STEP clock-enable generator driven by two debounced buttons.
// Optional STEP_COUNT_EN adds a 16-bit count of issued ce pulses.
module step_gear
    import step_gear_pkg::*;
#(
    parameter int unsigned SLOW          = 20,
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter int unsigned START_RUN     = 1
) (
    input logic        CLK,
    input logic        resetn,
    step_gear_if.slave bus
);

    localparam int unsigned PscW       = (SLOW == 0) ? 1 : SLOW;
    localparam state_e      ResetState = (START_RUN != 0) ? StRun : StHalt;

    logic            mode_ev;
    logic            step_ev;
    state_e          state_q;
    logic [PscW-1:0] psc_q;
    logic [PscW-1:0] psc_inc;
    logic            psc_wrap;
    logic            ce_q;
    logic            running_q;

    btn_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_mode_db (
        .clk_i   (CLK),
        .rst_ni  (resetn),
        .btn_i   (bus.btn_mode),
        .press_o (mode_ev)
    );

    btn_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_step_db (
        .clk_i   (CLK),
        .rst_ni  (resetn),
        .btn_i   (bus.btn_step),
        .press_o (step_ev)
    );

    assign psc_inc = psc_q + PscW'(1);

    // ce is registered, so it is raised on the edge that loads the all-ones prescaler value.
    if (SLOW == 0) begin : g_cont
        assign psc_wrap = 1'b1;
    end else begin : g_psc
        assign psc_wrap = &psc_inc;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ResetState;
            psc_q     <= '0;
            ce_q      <= 1'b0;
            running_q <= (START_RUN != 0);
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mode_ev) begin
                        state_q   <= StHalt;
                        ce_q      <= 1'b0;
                        running_q <= 1'b0;
                    end else begin
                        psc_q <= psc_inc;
                        ce_q  <= psc_wrap;
                    end
                end
                StHalt: begin
                    // Mode has priority over a simultaneous step press.
                    if (mode_ev) begin
                        state_q   <= StRun;
                        psc_q     <= '0;
                        ce_q      <= (SLOW == 0);
                        running_q <= 1'b1;
                    end else if (step_ev) begin
                        state_q <= StStep;
                        ce_q    <= 1'b1;
                    end else begin
                        ce_q <= 1'b0;
                    end
                end
                StStep: begin
                    state_q <= StHalt;
                    ce_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ResetState;
                    ce_q      <= 1'b0;
                    running_q <= (START_RUN != 0);
                end
            endcase
        end
    end

    assign bus.ce      = ce_q;
    assign bus.running = running_q;

`ifdef STEP_COUNT_EN
    logic [StepCountW-1:0] step_count_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            step_count_q <= '0;
        end else if (ce_q) begin
            step_count_q <= step_count_q + StepCountW'(1);
        end
    end

    assign bus.step_count = step_count_q;
`endif

endmodule
